alu_result_buffer: RTL and testbench
====================================

// Module: alu_result_buffer
// PURPOSE
//  Downstream stage of the 8-bit adder: captures {sum, carry, overflow} into a small
//  valid/ready FIFO, derives zero/negative flags at capture, presents them to the ALU consumer.
//  Decouples the combinational adder from a consumer that may stall; optionally counts overflows.
// PARAMETERS
//  WIDTH  8  data width of sum; must match adder width
//  DEPTH  2  FIFO entries; power of two, >= 2
//  CNT_W  8  width of overflow event counter (used only with OVF_COUNT_EN)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      adder result on in_* is valid
//  in_ready   out  1      buffer can accept (not full)
//  in_sum     in   WIDTH  adder sum (already zeroed by adder on overflow)
//  in_carry   in   1      adder carry out
//  in_ovf     in   1      adder overflow
//  out_valid  out  1      head entry valid
//  out_ready  in   1      consumer accepts head entry
//  out_sum    out  WIDTH  head sum
//  out_carry  out  1      head carry flag
//  out_ovf    out  1      head overflow flag
//  out_zero   out  1      head zero flag (out_sum == 0)
//  out_neg    out  1      head negative flag (out_sum[WIDTH-1])
//  cnt_clr    in   1      synchronous clear of overflow counter
//  ovf_count  out  CNT_W  overflow events accepted (saturating)
// BEHAVIOUR
//  - Reset (async, rst=1): wr/rd pointers and occupancy = 0; out_valid=0, in_ready=1,
//    out_sum=0, out_carry/ovf/zero/neg=0, ovf_count=0. Reset mid-transfer discards all entries.
//  - Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at posedge clk.
//  - in_ready = !full, from registered occupancy only; no combinational path from out_ready.
//  - Full + pop same cycle: no push that cycle (in_ready=0); in_ready rises the next cycle.
//  - Empty: no bypass. Entry pushed at edge N is on out_* after edge N (latency 1 cycle).
//  - Push+pop same cycle when neither empty nor full: occupancy unchanged, both pointers advance.
//  - Pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0; occupancy log2(DEPTH)+1 bits, 0..DEPTH.
//  - Flags computed at push and stored: zero = ~|in_sum, neg = in_sum[WIDTH-1].
//    Overflowed results arrive with sum=0, so ovf=1 entries always have zero=1, neg=0.
//  - out_* driven from the head entry; hold stable while out_valid=1 and out_ready=0.
//    When empty, out_* hold the last popped values (0 after reset); consumer qualifies with out_valid.
//  - in_valid while full: input ignored; upstream must hold data until in_ready.
//  - No state machine beyond occupancy: EMPTY (occ=0), PARTIAL, FULL (occ=DEPTH).
// CONFIGURATION
//  OVF_COUNT_EN defined:
//   - ovf_count increments on each push with in_ovf=1; saturates at 2^CNT_W-1.
//   - cnt_clr=1 sets it to 0 next edge; cnt_clr wins over a same-cycle increment.
//  OVF_COUNT_EN undefined: no counter logic; ovf_count tied to 0; cnt_clr ignored.
// TESTING
//  1 Reset: rst=1 mid-stream with 2 entries held -> out_valid=0, in_ready=1, ovf_count=0.
//  2 Single push: in_sum=8'h00, carry=1, ovf=0 -> next cycle out_valid=1, out_zero=1,
//    out_carry=1, out_neg=0.
//  3 Backpressure: out_ready=0, push 8'h81 then 8'h05 -> in_ready=0; third push ignored;
//    set out_ready=1 -> pops 8'h81 (neg=1) then 8'h05 in order; in_ready=1 the cycle after first pop.
//  4 Streaming: in_valid=out_ready=1 for 10 cycles, sums 1..10 -> all 10 out in order,
//    no loss or duplicate; pointers wrap.
//  5 Overflow (OVF_COUNT_EN): push 3 entries with ovf=1 (sum=0) -> out_ovf=1, out_zero=1,
//    ovf_count=3; cnt_clr with a same-cycle ovf push -> ovf_count=0.
//  6 Saturation (OVF_COUNT_EN, CNT_W=2): 5 ovf pushes -> ovf_count=3; undefined macro -> always 0.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Purpose : valid/ready FIFO behind the 8-bit adder; stores {sum, carry, ovf} and
//           derives zero/neg flags at capture time, presenting the head entry to the ALU consumer.
// Latency : 1 cycle (entry pushed at edge N is visible on out_* after edge N, no empty bypass).
// Backpr. : in_ready = !full from registered occupancy only; out_* hold while out_ready=0.
// Option  : define OVF_COUNT_EN to build the saturating overflow event counter
//           (otherwise ovf_count is tied to 0 and cnt_clr is ignored).
// Ports   : clk, rst (async, active-high)
//           in_valid/in_ready/in_sum/in_carry/in_ovf       - producer side (adder result)
//           out_valid/out_ready/out_sum/out_carry/out_ovf  - consumer side, head entry
//           out_zero/out_neg                               - flags stored with the entry
//           cnt_clr/ovf_count                              - overflow event counter
module alu_result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  // Entry flags packed as {carry, ovf, zero, neg}
  logic [WIDTH-1:0] mem_sum [DEPTH];
  logic [3:0]       mem_flg [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_nxt;
  logic             push;
  logic             pop;
  logic             head_from_in;
  logic [3:0]       in_flg;

  assign in_ready  = (occ != FULL_OCC);
  assign out_valid = (occ != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_flg    = {in_carry, in_ovf, ~|in_sum, in_sum[WIDTH-1]};

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    occ_nxt    = occ;
    if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
    if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
    case ({push, pop})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase
  end

  // The new head is the entry being written this cycle only when the queue
  // drains down to (or starts from) just that entry.
  assign head_from_in = push && (rd_ptr_nxt == wr_ptr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      occ    <= occ_nxt;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sum[wr_ptr] <= in_sum;
      mem_flg[wr_ptr] <= in_flg;
    end
  end

  // Registered head copy: keeps out_* at the last popped values when the
  // queue empties, instead of exposing stale storage at rd_ptr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
    end else if (occ_nxt != '0) begin
      if (head_from_in) begin
        out_sum                                <= in_sum;
        {out_carry, out_ovf, out_zero, out_neg} <= in_flg;
      end else begin
        out_sum                                <= mem_sum[rd_ptr_nxt];
        {out_carry, out_ovf, out_zero, out_neg} <= mem_flg[rd_ptr_nxt];
      end
    end
  end

`ifdef OVF_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (push && in_ovf && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign ovf_count = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign ovf_count      = '0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Purpose : directed self-checking bench for alu_result_buffer (DEPTH=2), plus a
//           CNT_W=2 instance sharing the same stimulus to exercise counter saturation.
// Ports   : none (top-level bench); clock 10 ns period.
module tb_alu_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sum;
  logic       in_carry;
  logic       in_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_carry;
  logic       out_ovf;
  logic       out_zero;
  logic       out_neg;
  logic       cnt_clr;
  logic [7:0] ovf_count;

  logic       s_in_ready;
  logic       s_out_valid;
  logic [7:0] s_out_sum;
  logic       s_out_carry;
  logic       s_out_ovf;
  logic       s_out_zero;
  logic       s_out_neg;
  logic [1:0] s_ovf_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_result_buffer #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_carry(in_carry), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg),
    .cnt_clr(cnt_clr), .ovf_count(ovf_count)
  );

  alu_result_buffer #(.WIDTH(8), .DEPTH(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_sum(in_sum),
    .in_carry(in_carry), .in_ovf(in_ovf),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
    .out_carry(s_out_carry), .out_ovf(s_out_ovf), .out_zero(s_out_zero), .out_neg(s_out_neg),
    .cnt_clr(cnt_clr), .ovf_count(s_ovf_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] s, input logic c, input logic o);
    in_valid = v;
    in_sum   = s;
    in_carry = c;
    in_ovf   = o;
  endtask

  int exp_cnt3;
  int exp_cnt5;
  int exp_sat;
  int popped;
  logic [7:0] exp_next;

  initial begin
`ifdef OVF_COUNT_EN
    exp_cnt3 = 3;
    exp_cnt5 = 5;
    exp_sat  = 3;
`else
    exp_cnt3 = 0;
    exp_cnt5 = 0;
    exp_sat  = 0;
`endif
    rst = 1'b1;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_flags",     32'({out_carry, out_ovf, out_zero, out_neg}), 32'd0);
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
    rst = 1'b0;
    tick();

    // Single push of a zero sum with carry
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_zero",  32'(out_zero),  32'd1);
    check("single_carry", 32'(out_carry), 32'd1);
    check("single_neg",   32'(out_neg),   32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_popped_empty", 32'(out_valid), 32'd0);
    check("single_hold_carry",   32'(out_carry), 32'd1);

    // Backpressure: fill, ignored third push, drain in order
    drive(1'b1, 8'h81, 1'b0, 1'b0);
    tick();
    check("bp_first_sum", 32'(out_sum), 32'h81);
    check("bp_first_neg", 32'(out_neg), 32'd1);
    check("bp_rdy_one",   32'(in_ready), 32'd1);
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    tick();
    check("bp_full_rdy",  32'(in_ready), 32'd0);
    check("bp_head_hold", 32'(out_sum),  32'h81);
    drive(1'b1, 8'h7f, 1'b0, 1'b0);
    tick();
    check("bp_ignored_rdy",  32'(in_ready), 32'd0);
    check("bp_ignored_head", 32'(out_sum),  32'h81);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check("bp_pop2_sum", 32'(out_sum),   32'h05);
    check("bp_pop2_neg", 32'(out_neg),   32'd0);
    check("bp_rdy_back", 32'(in_ready),  32'd1);
    check("bp_pop2_vld", 32'(out_valid), 32'd1);
    tick();
    check("bp_empty_vld",  32'(out_valid), 32'd0);
    check("bp_empty_hold", 32'(out_sum),   32'h05);

    // Reset mid-stream with two entries held
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_ovf_count", 32'(ovf_count), 32'd0);
    check("midrst_out_sum",   32'(out_sum),   32'd0);
    rst = 1'b0;
    tick();

    // Streaming sums 1..10 through a continuously ready consumer
    out_ready = 1'b1;
    popped    = 0;
    exp_next  = 8'd1;
    for (int i = 1; i <= 12; i++) begin
      if (i <= 10) drive(1'b1, 8'(i), 1'b0, 1'b0);
      else         drive(1'b0, 8'h00, 1'b0, 1'b0);
      if (out_valid && out_ready) begin
        check("stream_order", 32'(out_sum), 32'(exp_next));
        exp_next = exp_next + 8'd1;
        popped++;
      end
      tick();
      if (i <= 10) check("stream_rdy", 32'(in_ready), 32'd1);
    end
    check("stream_count", 32'(popped), 32'd10);
    check("stream_drained", 32'(out_valid), 32'd0);

    // Overflow entries and counter
    drive(1'b1, 8'h00, 1'b1, 1'b1);
    tick();
    check("ovf_flag", 32'(out_ovf),  32'd1);
    check("ovf_zero", 32'(out_zero), 32'd1);
    check("ovf_neg",  32'(out_neg),  32'd0);
    tick();
    tick();
    check("ovf_count3", 32'(ovf_count), 32'(exp_cnt3));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("ovf_clr_wins", 32'(ovf_count), 32'd0);

    // Saturation: five more overflow pushes
    for (int i = 0; i < 5; i++) tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_count5", 32'(ovf_count),   32'(exp_cnt5));
    check("ovf_sat",    32'(s_ovf_count), 32'(exp_sat));
    tick();
    tick();
    check("final_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
